// File: rtl/ls74194.sv
// 4-bit bidirectional universal shift register (74LS194 equivalent).
// Hold, shift right, shift left and parallel load with async clear.
module ls74194 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] p,
  input  logic             sil,
  input  logic             sir,
  output logic [WIDTH-1:0] q
);

  logic             hold;
  logic             shr;
  logic             shl;
  logic             load;
  logic [WIDTH-1:0] q_nxt;

  assign hold = (s == 2'b00);
  assign shr  = (s == 2'b01);
  assign shl  = (s == 2'b10);
  assign load = (s == 2'b11);

  // sir fills the top bit, sil fills the bottom bit
  always_comb begin
    q_nxt = q;
    unique case (1'b1)
      hold: q_nxt = q;
      shr:  q_nxt = {sir, q[WIDTH-1:1]};
      shl:  q_nxt = {q[WIDTH-2:0], sil};
      load: q_nxt = p;
      default: q_nxt = q;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q <= '0;
    end else begin
      q <= q_nxt;
    end
  end

endmodule

// File: tb/tb_ls74194.sv
// Directed self-checking bench for ls74194.
// Inputs change on the falling edge; q is sampled 1 ns after rising edges.
module tb_ls74194;

  logic       clk;
  logic       clear_n;
  logic [1:0] s;
  logic [3:0] p;
  logic       sil;
  logic       sir;
  logic [3:0] q;

  int n_pass;
  int n_tot;

  ls74194 #(.WIDTH(4)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .s       (s),
    .p       (p),
    .sil     (sil),
    .sir     (sir),
    .q       (q)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [3:0] obs,
    input logic [3:0] exp
  );
    n_tot++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive on falling edge, sample just after the next rising edge
  task automatic cyc(
    input logic       cn,
    input logic [1:0] sm,
    input logic [3:0] pd,
    input logic       l,
    input logic       r
  );
    @(negedge clk);
    clear_n = cn;
    s       = sm;
    p       = pd;
    sil     = l;
    sir     = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_tot   = 0;
    clear_n = 1'b0;
    s       = 2'b00;
    p       = 4'b1010;
    sil     = 1'b0;
    sir     = 1'b0;

    #1;
    chk("clr_pre_edge", q, 4'b0000);
    @(posedge clk);
    #1;
    chk("clr_edge", q, 4'b0000);

    cyc(1'b1, 2'b11, 4'b1010, 1'b0, 1'b0);
    chk("load_1010", q, 4'b1010);

    cyc(1'b1, 2'b01, 4'b0000, 1'b0, 1'b0);
    chk("shr_sir0", q, 4'b0101);
    cyc(1'b1, 2'b01, 4'b0000, 1'b0, 1'b1);
    chk("shr_sir1", q, 4'b1010);

    cyc(1'b1, 2'b01, 4'b1111, 1'b1, 1'b0);
    chk("shr_to_0101", q, 4'b0101);
    cyc(1'b1, 2'b10, 4'b0000, 1'b1, 1'b0);
    chk("shl_sil1", q, 4'b1011);

    cyc(1'b1, 2'b00, 4'b1010, 1'b0, 1'b1);
    chk("hold_1", q, 4'b1011);
    cyc(1'b1, 2'b00, 4'b0110, 1'b1, 1'b0);
    chk("hold_2", q, 4'b1011);
    cyc(1'b1, 2'b00, 4'b0001, 1'b1, 1'b1);
    chk("hold_3", q, 4'b1011);

    cyc(1'b1, 2'b11, 4'b1010, 1'b0, 1'b0);
    chk("load_again", q, 4'b1010);
    cyc(1'b1, 2'b10, 4'b0000, 1'b1, 1'b0);
    chk("shl_drop_msb", q, 4'b0101);
    cyc(1'b1, 2'b10, 4'b0000, 1'b0, 1'b1);
    chk("shl_sil0", q, 4'b1010);

    // Inputs moving mid-cycle must not reach q before the edge
    #4;
    s = 2'b11;
    p = 4'b0011;
    #2;
    chk("no_comb_path", q, 4'b1010);
    @(posedge clk);
    #1;
    chk("load_0011", q, 4'b0011);

    cyc(1'b1, 2'b11, 4'b1010, 1'b0, 1'b0);
    chk("load_pre_clr", q, 4'b1010);
    #4;
    clear_n = 1'b0;
    #1;
    chk("async_clr", q, 4'b0000);
    cyc(1'b0, 2'b11, 4'b1010, 1'b1, 1'b1);
    chk("clr_beats_load", q, 4'b0000);
    cyc(1'b1, 2'b11, 4'b0110, 1'b0, 1'b0);
    chk("load_after_rel", q, 4'b0110);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
